// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/pause/lap/clear controller for a cascaded MM:SS BCD
// stopwatch (00:00 .. 59:59) with a built-in count-tick prescaler.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   start_stop  one-cycle pulse, toggles run/pause
//   lap         one-cycle pulse, enters/leaves lap freeze
//   clr         one-cycle pulse, zeroes counts when stopped (IDLE/PAUSE)
//   disp        BCD digits {m1,m0,s1,s0}: lap snapshot in LAP, live otherwise
//   state       FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3
//   run         high in RUN or LAP
//   lap_active  high in LAP
//   tick        one-cycle pulse with each count update
//   ovf         one-cycle pulse with the 59:59 -> 00:00 wrap
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clr,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        run,
    output logic        lap_active,
    output logic        tick,
    output logic        ovf
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0] CNT_MAX = 16'h5959;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   cnt_q, cnt_d, cnt_inc;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   disp_d;
    logic          counting, wrap, clr_acc;
    logic          tick_d, ovf_d, run_d, lap_active_d;

    // Next value of the BCD digit cascade for one count increment.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q[3:0] != 4'd9) begin
            cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (cnt_q[7:4] != 4'd5) begin
                cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
            end else begin
                cnt_inc[7:4] = 4'd0;
                if (cnt_q[11:8] != 4'd9) begin
                    cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
                end else begin
                    cnt_inc[11:8] = 4'd0;
                    if (cnt_q[15:12] != 4'd5) begin
                        cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
                    end else begin
                        cnt_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    // Next-state, prescaler, counts, snapshot and registered-output values.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        cnt_d        = cnt_q;
        snap_d       = snap_q;
        counting     = (state_q == RUN) || (state_q == LAP);
        wrap         = counting && (presc_q == PRESC_MAX);
        clr_acc      = clr && ((state_q == IDLE) || (state_q == PAUSE));
        tick_d       = 1'b0;
        ovf_d        = 1'b0;
        run_d        = 1'b0;
        lap_active_d = 1'b0;
        disp_d       = 16'h0000;

        // Priority clr > start_stop > lap among the inputs each state accepts.
        case (state_q)
            IDLE: begin
                if (!clr && start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop)  state_d = PAUSE;
                else if (lap)    state_d = LAP;
            end
            LAP: begin
                if (start_stop)  state_d = PAUSE;
                else if (lap)    state_d = RUN;
            end
            PAUSE: begin
                if (clr)             state_d = IDLE;
                else if (start_stop) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        // Counting is judged on the current state, so a pause accepted on a
        // wrap edge still increments and a resume edge never does.
        if (clr_acc) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = wrap ? '0 : presc_q + PW'(1);
        end else if (state_q == IDLE) begin
            presc_d = '0;
        end

        if (clr_acc) begin
            cnt_d = 16'h0000;
        end else if (wrap) begin
            cnt_d = cnt_inc;
        end

        // Snapshot takes the pre-increment value on the entry edge.
        if ((state_q == RUN) && (state_d == LAP)) begin
            snap_d = cnt_q;
        end

        tick_d       = wrap;
        ovf_d        = wrap && (cnt_q == CNT_MAX);
        run_d        = (state_d == RUN) || (state_d == LAP);
        lap_active_d = (state_d == LAP);
        disp_d       = lap_active_d ? snap_d : cnt_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            cnt_q      <= 16'h0000;
            snap_q     <= 16'h0000;
            disp       <= 16'h0000;
            run        <= 1'b0;
            lap_active <= 1'b0;
            tick       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            disp       <= disp_d;
            run        <= run_d;
            lap_active <= lap_active_d;
            tick       <= tick_d;
            ovf        <= ovf_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl: the driver issues one input vector per
// cycle and pushes the outputs a seconds-based model expects after that edge;
// an independent monitor pops and compares after every rising edge.
module tb_stopwatch_ctrl;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] disp;
    logic [1:0]  state;
    logic        run, lap_active, tick, ovf;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clr        (clr),
        .disp       (disp),
        .state      (state),
        .run        (run),
        .lap_active (lap_active),
        .tick       (tick),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] disp;
        logic        run;
        logic        lap;
        logic        tick;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   seen_ovf = 0;
    int   model_ovf = 0;

    // Model: elapsed time as whole seconds, modes as small integers.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
    int m_st = M_IDLE;
    int m_presc = 0;
    int m_total = 0;
    int m_snap = 0;

    function automatic logic [15:0] to_bcd(input int t);
        int mm, ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_edge(input bit r, input bit ss, input bit lp, input bit cl);
        exp_t e;
        int   nst;
        bit   tk, ov;
        tk = 0;
        ov = 0;
        if (!r) begin
            m_st = M_IDLE; m_presc = 0; m_total = 0; m_snap = 0;
        end else begin
            nst = m_st;
            if (cl && (m_st == M_IDLE || m_st == M_PAUSE)) begin
                m_total = 0;
                m_presc = 0;
                nst = M_IDLE;
            end else begin
                if (m_st == M_RUN || m_st == M_LAP) begin
                    if (m_presc == TD - 1) begin
                        m_presc = 0;
                        tk = 1;
                        if (m_total == 3599) begin ov = 1; m_total = 0; end
                        else m_total = m_total + 1;
                    end else begin
                        m_presc = m_presc + 1;
                    end
                end
                case (m_st)
                    M_IDLE:  if (ss) nst = M_RUN;
                    M_RUN:   if (ss) nst = M_PAUSE; else if (lp) begin nst = M_LAP; m_snap = tk ? m_total - 1 : m_total; end
                    M_LAP:   if (ss) nst = M_PAUSE; else if (lp) nst = M_RUN;
                    default: if (ss) nst = M_RUN;
                endcase
                // a snapshot taken on the 59:59 wrap edge keeps 59:59
                if (m_snap < 0) m_snap = 3599;
            end
            m_st = nst;
        end
        if (ov) model_ovf++;
        e.st   = 2'(m_st);
        e.disp = (m_st == M_LAP) ? to_bcd(m_snap) : to_bcd(m_total);
        e.run  = (m_st == M_RUN) || (m_st == M_LAP);
        e.lap  = (m_st == M_LAP);
        e.tick = tk;
        e.ovf  = ov;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs and record what should appear after its edge.
    task automatic step(input bit r, input bit ss, input bit lp, input bit cl);
        @(negedge clk);
        rst_n = r; start_stop = ss; lap = lp; clr = cl;
        model_edge(r, ss, lp, cl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    // Monitor: every edge presents a full output set.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ovf) seen_ovf++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {state, disp, run, lap_active, tick, ovf};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle %0d: got st=%0d disp=%h run=%b lap=%b tick=%b ovf=%b, want st=%0d disp=%h run=%b lap=%b tick=%b ovf=%b",
                             cyc, a.st, a.disp, a.run, a.lap, a.tick, a.ovf,
                             e.st, e.disp, e.run, e.lap, e.tick, e.ovf);
                end
            end
        end
    end

    initial begin
        int n;
        // reset held with start_stop high, then quiet IDLE
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        idle(6);
        // run 40 cycles from IDLE
        step(1, 1, 0, 0);
        idle(40);
        // pause with held prescaler 2, wait, resume
        n = 0;
        while (m_presc != 1 && n < 8) begin idle(1); n++; end
        step(1, 1, 0, 0);
        idle(20);
        step(1, 1, 0, 0);
        idle(6);
        // clr ignored while running
        step(1, 0, 0, 1);
        idle(3);
        // clear, restart, lap at 00:07 for 8 ticks (clr tried inside LAP)
        step(1, 1, 0, 0);
        step(1, 0, 0, 1);
        step(1, 1, 0, 0);
        n = 0;
        while (m_total != 7 && n < 100) begin idle(1); n++; end
        step(1, 0, 1, 0);
        idle(16);
        step(1, 0, 0, 1);
        idle(15);
        step(1, 0, 1, 0);
        idle(3);
        // start_stop+lap in RUN, then clr+start_stop in PAUSE
        step(1, 1, 1, 0);
        idle(2);
        step(1, 1, 0, 1);
        idle(3);
        // full overflow from 00:00
        step(1, 1, 0, 0);
        idle(3600 * TD + 12);
        // randomized pulses with occasional reset
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 11) == 0));
        end
        idle(2);
        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        n_cmp++;
        if (seen_ovf != model_ovf) begin
            n_bad++;
            $display("FAIL ovf_count: got %0d, want %0d", seen_ovf, model_ovf);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
